// File: rtl/arbitration_field_sequencer_if.sv
// Bundles the bit-stream inputs and the arbitration-field outputs of the sequencer.
interface arbitration_field_sequencer_if #(
  parameter int unsigned BASE_W = 11,
  parameter int unsigned EXT_W  = 18
);
  logic              sp_i;
  logic              rx_bit_i;
  logic              stuff_i;
  logic              start_i;
  logic              abort_i;
  logic              release_i;
  logic [BASE_W-1:0] idf_o;
  logic [EXT_W-1:0]  idf_ex_o;
  logic              ide_o;
  logic              rtr_o;
  logic              busy_o;
  logic              f_idf_o;
  logic              form_err_o;

  // Sequencer side: consumes the bit stream and controls, produces the field.
  modport slave (
    input  sp_i, rx_bit_i, stuff_i, start_i, abort_i, release_i,
    output idf_o, idf_ex_o, ide_o, rtr_o, busy_o, f_idf_o, form_err_o
  );

  // Upstream/consumer side: drives the bit stream and controls, observes the field.
  modport master (
    output sp_i, rx_bit_i, stuff_i, start_i, abort_i, release_i,
    input  idf_o, idf_ex_o, ide_o, rtr_o, busy_o, f_idf_o, form_err_o
  );
endinterface

// File: rtl/arbitration_field_sequencer.sv
// Receives the CAN arbitration field bit by bit on de-stuffed sample points and
// presents the base/extended identifier, IDE and RTR with a completion flag.
module arbitration_field_sequencer #(
  parameter int unsigned BASE_W = 11,
  parameter int unsigned EXT_W  = 18,
  parameter int unsigned CNT_W  = 5
) (
  input  logic                           clock,
  input  logic                           reset,
  arbitration_field_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_BASE    = 3'd1,
    S_SRR_RTR = 3'd2,
    S_IDE_B   = 3'd3,
    S_EXT     = 3'd4,
    S_EXT_RTR = 3'd5,
    S_DONE    = 3'd6
  } state_e;

  localparam logic [CNT_W-1:0] BASE_LAST = CNT_W'(BASE_W - 1);
  localparam logic [CNT_W-1:0] EXT_LAST  = CNT_W'(EXT_W - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BASE_W-1:0] idf_q, idf_d;
  logic [EXT_W-1:0]  idf_ex_q, idf_ex_d;
  logic              ide_q, ide_d;
  logic              rtr_q, rtr_d;
  logic              srr_q, srr_d;
  logic              busy_q, busy_d;
  logic              f_idf_q, f_idf_d;
  logic              form_err_q, form_err_d;
  logic              bit_ev_c;

  // A bit event is a sample point that does not carry a stuff bit.
  assign bit_ev_c = bus.sp_i & ~bus.stuff_i;

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idf_q      <= '0;
      idf_ex_q   <= '0;
      ide_q      <= 1'b0;
      rtr_q      <= 1'b0;
      srr_q      <= 1'b0;
      busy_q     <= 1'b0;
      f_idf_q    <= 1'b0;
      form_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idf_q      <= idf_d;
      idf_ex_q   <= idf_ex_d;
      ide_q      <= ide_d;
      rtr_q      <= rtr_d;
      srr_q      <= srr_d;
      busy_q     <= busy_d;
      f_idf_q    <= f_idf_d;
      form_err_q <= form_err_d;
    end
  end

  // Next-state and field capture; abort overrides everything, including a same-cycle bit.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idf_d      = idf_q;
    idf_ex_d   = idf_ex_q;
    ide_d      = ide_q;
    rtr_d      = rtr_q;
    srr_d      = srr_q;
    form_err_d = 1'b0;

    if (bus.abort_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bit_ev_c && bus.start_i && !bus.rx_bit_i) begin
            state_d  = S_BASE;
            idf_d    = '0;
            idf_ex_d = '0;
            ide_d    = 1'b0;
            rtr_d    = 1'b0;
            cnt_d    = '0;
          end
        end
        S_BASE: begin
          if (bit_ev_c) begin
            idf_d = {idf_q[BASE_W-2:0], bus.rx_bit_i};
            if (cnt_q == BASE_LAST) begin
              state_d = S_SRR_RTR;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        S_SRR_RTR: begin
          if (bit_ev_c) begin
            srr_d   = bus.rx_bit_i;
            state_d = S_IDE_B;
          end
        end
        S_IDE_B: begin
          if (bit_ev_c) begin
            ide_d = bus.rx_bit_i;
            if (!bus.rx_bit_i) begin
              rtr_d   = srr_q;
              state_d = S_DONE;
            end else begin
              form_err_d = ~srr_q;
              cnt_d      = '0;
              state_d    = S_EXT;
            end
          end
        end
        S_EXT: begin
          if (bit_ev_c) begin
            idf_ex_d = {idf_ex_q[EXT_W-2:0], bus.rx_bit_i};
            if (cnt_q == EXT_LAST) begin
              state_d = S_EXT_RTR;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        S_EXT_RTR: begin
          if (bit_ev_c) begin
            rtr_d   = bus.rx_bit_i;
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (bus.release_i) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
    f_idf_d = (state_d == S_DONE);
  end

  assign bus.idf_o      = idf_q;
  assign bus.idf_ex_o   = idf_ex_q;
  assign bus.ide_o      = ide_q;
  assign bus.rtr_o      = rtr_q;
  assign bus.busy_o     = busy_q;
  assign bus.f_idf_o    = f_idf_q;
  assign bus.form_err_o = form_err_q;

endmodule

// File: tb/tb_arbitration_field_sequencer.sv
// Directed bench for the arbitration field sequencer.
module tb_arbitration_field_sequencer;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  int   fe_cnt;
  int   rise_cnt;
  int   fe_base;
  int   rise_base;
  logic fidf_prev;

  arbitration_field_sequencer_if #(.BASE_W(11), .EXT_W(18)) bus ();

  arbitration_field_sequencer #(.BASE_W(11), .EXT_W(18), .CNT_W(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count form_err pulses and F_IDF rising edges, sampled just after each edge.
  always @(posedge clock) begin
    #1;
    if (bus.form_err_o === 1'b1) fe_cnt++;
    if (bus.f_idf_o === 1'b1 && fidf_prev !== 1'b1) rise_cnt++;
    fidf_prev = bus.f_idf_o;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One sample point, held for a single clock, then deasserted.
  task automatic send(input logic b, input logic stf, input logic ab);
    @(negedge clock);
    bus.sp_i     = 1'b1;
    bus.rx_bit_i = b;
    bus.stuff_i  = stf;
    bus.abort_i  = ab;
    @(negedge clock);
    bus.sp_i     = 1'b0;
    bus.stuff_i  = 1'b0;
    bus.abort_i  = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send(v[i], 1'b0, 1'b0);
  endtask

  task automatic pulse_release();
    @(negedge clock);
    bus.release_i = 1'b1;
    @(negedge clock);
    bus.release_i = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; fe_cnt = 0; rise_cnt = 0; fidf_prev = 1'b0;
    bus.sp_i = 1'b0; bus.rx_bit_i = 1'b1; bus.stuff_i = 1'b0;
    bus.start_i = 1'b0; bus.abort_i = 1'b0; bus.release_i = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_idf", 32'(bus.idf_o), 32'h0);
    chk("rst_busy", 32'(bus.busy_o), 32'h0);
    chk("rst_fidf", 32'(bus.f_idf_o), 32'h0);
    reset = 1'b1;
    bus.start_i = 1'b1;

    // Recessive bits and dominant stuff SPs in IDLE do not start a frame.
    send(1'b1, 1'b0, 1'b0);
    chk("idle_rec_busy", 32'(bus.busy_o), 32'h0);
    send(1'b0, 1'b1, 1'b0);
    chk("idle_stuff_busy", 32'(bus.busy_o), 32'h0);

    // 1: base frame 0x123, RTR 0, IDE 0.
    send(1'b0, 1'b0, 1'b0);
    chk("t1_busy_sof", 32'(bus.busy_o), 32'h1);
    send_bits(32'h123, 11);
    send(1'b0, 1'b0, 1'b0);
    chk("t1_fidf_ev13", 32'(bus.f_idf_o), 32'h0);
    send(1'b0, 1'b0, 1'b0);
    chk("t1_fidf_ev14", 32'(bus.f_idf_o), 32'h1);
    chk("t1_busy", 32'(bus.busy_o), 32'h0);
    chk("t1_idf", 32'(bus.idf_o), 32'h123);
    chk("t1_idf_ex", 32'(bus.idf_ex_o), 32'h0);
    chk("t1_ide", 32'(bus.ide_o), 32'h0);
    chk("t1_rtr", 32'(bus.rtr_o), 32'h0);
    send(1'b1, 1'b0, 1'b0);
    chk("t1_done_hold_idf", 32'(bus.idf_o), 32'h123);
    chk("t1_done_hold_fidf", 32'(bus.f_idf_o), 32'h1);
    pulse_release();
    chk("t1_rel_fidf", 32'(bus.f_idf_o), 32'h0);
    chk("t1_rel_idf", 32'(bus.idf_o), 32'h123);

    // 2: extended frame 0x5A5 / 0x2AAAA, SRR 1, IDE 1, RTR 1.
    fe_base = fe_cnt;
    send(1'b0, 1'b0, 1'b0);
    send_bits(32'h5A5, 11);
    send(1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b0, 1'b0);
    send_bits(32'h2AAAA, 18);
    chk("t2_fidf_ev32", 32'(bus.f_idf_o), 32'h0);
    send(1'b1, 1'b0, 1'b0);
    chk("t2_fidf_ev33", 32'(bus.f_idf_o), 32'h1);
    chk("t2_idf", 32'(bus.idf_o), 32'h5A5);
    chk("t2_idf_ex", 32'(bus.idf_ex_o), 32'h2AAAA);
    chk("t2_ide", 32'(bus.ide_o), 32'h1);
    chk("t2_rtr", 32'(bus.rtr_o), 32'h1);
    pulse_release();
    chk("t2_no_form_err", 32'(fe_cnt - fe_base), 32'h0);

    // 3: base 0x7FF with stuff SPs after each run of five equal bits.
    send(1'b0, 1'b0, 1'b0);
    repeat (5) send(1'b1, 1'b0, 1'b0);
    send(1'b0, 1'b1, 1'b0);
    chk("t3_after_stuff_idf", 32'(bus.idf_o), 32'h1F);
    chk("t3_after_stuff_busy", 32'(bus.busy_o), 32'h1);
    repeat (5) send(1'b1, 1'b0, 1'b0);
    send(1'b0, 1'b1, 1'b0);
    send(1'b1, 1'b0, 1'b0);
    send(1'b0, 1'b0, 1'b0);
    chk("t3_fidf_ev13", 32'(bus.f_idf_o), 32'h0);
    send(1'b0, 1'b0, 1'b0);
    chk("t3_fidf_ev14", 32'(bus.f_idf_o), 32'h1);
    chk("t3_idf", 32'(bus.idf_o), 32'h7FF);
    pulse_release();

    // 4: abort on the 6th base bit, then a fresh frame with ID 0x001.
    rise_base = rise_cnt;
    send(1'b0, 1'b0, 1'b0);
    send_bits(32'h15, 5);
    send(1'b1, 1'b0, 1'b1);
    chk("t4_abort_busy", 32'(bus.busy_o), 32'h0);
    chk("t4_abort_idf_partial", 32'(bus.idf_o), 32'h015);
    send(1'b0, 1'b0, 1'b0);
    send_bits(32'h001, 11);
    send(1'b0, 1'b0, 1'b0);
    send(1'b0, 1'b0, 1'b0);
    chk("t4_fidf", 32'(bus.f_idf_o), 32'h1);
    chk("t4_idf", 32'(bus.idf_o), 32'h001);
    pulse_release();
    chk("t4_fidf_rises", 32'(rise_cnt - rise_base), 32'h1);

    // 5: extended frame with dominant SRR raises one form_err pulse.
    fe_base = fe_cnt;
    send(1'b0, 1'b0, 1'b0);
    send_bits(32'h0F0, 11);
    send(1'b0, 1'b0, 1'b0);
    send(1'b1, 1'b0, 1'b0);
    chk("t5_form_err_pulse", 32'(bus.form_err_o), 32'h1);
    send_bits(32'h00001, 18);
    chk("t5_form_err_gone", 32'(bus.form_err_o), 32'h0);
    send(1'b0, 1'b0, 1'b0);
    chk("t5_fidf", 32'(bus.f_idf_o), 32'h1);
    chk("t5_ide", 32'(bus.ide_o), 32'h1);
    chk("t5_rtr", 32'(bus.rtr_o), 32'h0);
    chk("t5_idf_ex", 32'(bus.idf_ex_o), 32'h00001);
    pulse_release();
    chk("t5_form_err_count", 32'(fe_cnt - fe_base), 32'h1);

    // 6: async reset mid-EXT, then a frame with release held throughout.
    send(1'b0, 1'b0, 1'b0);
    send_bits(32'h3C3, 11);
    send(1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b0, 1'b0);
    send_bits(32'h15, 5);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_idf", 32'(bus.idf_o), 32'h0);
    chk("t6_rst_idf_ex", 32'(bus.idf_ex_o), 32'h0);
    chk("t6_rst_ide", 32'(bus.ide_o), 32'h0);
    chk("t6_rst_busy", 32'(bus.busy_o), 32'h0);
    @(negedge clock);
    #2 reset = 1'b1;
    bus.release_i = 1'b1;
    send(1'b0, 1'b0, 1'b0);
    send_bits(32'h0AB, 11);
    chk("t6_busy_rel_ignored", 32'(bus.busy_o), 32'h1);
    send(1'b0, 1'b0, 1'b0);
    send(1'b0, 1'b0, 1'b0);
    chk("t6_fidf", 32'(bus.f_idf_o), 32'h1);
    @(negedge clock);
    chk("t6_rel_fidf", 32'(bus.f_idf_o), 32'h0);
    chk("t6_rel_idf", 32'(bus.idf_o), 32'h0AB);
    chk("t6_rel_busy", 32'(bus.busy_o), 32'h0);
    bus.release_i = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
